// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared types and sizing helpers for the fxp_* arithmetic blocks
package fxp_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} fxp_iter_st_t;

    // Number of root bits the restoring square root must produce for a given format
    function automatic int fxp_sqrt_nb(input int wii, input int wif, input int wof);
        int s;
        int w;
        s = 2 * wof + 2 - wif;
        w = wii + wif + s;
        return (w + 1) / 2;
    endfunction

endpackage

// File: rtl/fxp_sqrt_iter.sv
// rtl/fxp_sqrt_iter.sv - iterative restoring fixed-point square root, one root bit per clock
module fxp_sqrt_iter
    import fxp_pkg::*;
#(
    parameter int WII   = 8,
    parameter int WIF   = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROUND = 1
) (
    input  logic                 rstn,
    input  logic                 clk,
    input  logic                 i_vld,
    output logic                 i_rdy,
    input  logic [WII+WIF-1:0]   in,
    output logic                 o_vld,
    input  logic                 o_rdy,
    output logic [WOI+WOF-1:0]   out,
    output logic                 overflow
);

    localparam int WI   = WII + WIF;
    localparam int WO   = WOI + WOF;
    localparam int S    = 2 * WOF + 2 - WIF;
    localparam int NB   = fxp_sqrt_nb(WII, WIF, WOF);
    localparam int WRAD = 2 * NB;
    localparam int WREM = NB + 2;
    localparam int WCNT = $clog2(NB + 1);
    localparam int WC   = (NB + 1 > WO) ? NB + 1 : WO;
    localparam bit RND  = (ROUND != 0);
    localparam logic [WC-1:0] SAT_MAX = {{(WC - WO + 1){1'b0}}, {(WO - 1){1'b1}}};

    fxp_iter_st_t state, state_nxt;

    logic [WRAD-1:0] rad;
    logic [WRAD-1:0] rad_init;
    logic [WREM-1:0] rem;
    logic [WREM-1:0] rem_sh;
    logic [WREM-1:0] trial;
    logic [NB-1:0]   q;
    logic [WCNT-1:0] cnt;
    logic            neg;
    logic            ge;
    logic [NB:0]     q_ext;
    logic [NB:0]     r_full;
    logic [WC-1:0]   r_ext;
    logic            sat;

    // Radicand aligned so that isqrt yields WOF+1 fractional bits (one guard bit for rounding)
    generate
        if (S >= 0) begin : g_shl
            assign rad_init = WRAD'(in) << S;
        end else begin : g_shr
            assign rad_init = WRAD'(in >> (-S));
        end
    endgenerate

    assign rem_sh = WREM'({rem, rad[WRAD-1 -: 2]});
    assign trial  = {q, 2'b01};
    assign ge     = (rem_sh >= trial);

    assign q_ext  = {1'b0, q};
    assign r_full = RND ? ((q_ext + (NB + 1)'(1)) >> 1) : (q_ext >> 1);
    assign r_ext  = WC'(r_full);
    assign sat    = (r_ext > SAT_MAX);

    assign i_rdy = (state == IDLE);
    assign o_vld = (state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A negative operand still passes through CALC for one cycle, but skips the iterations
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (i_vld) state_nxt = CALC;
            CALC: if (neg || cnt == '0) state_nxt = FIN;
            FIN:  state_nxt = DONE;
            DONE: if (o_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rad      <= '0;
            rem      <= '0;
            q        <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            out      <= '0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_vld) begin
                        neg <= in[WI-1];
                        rad <= in[WI-1] ? '0 : rad_init;
                        rem <= '0;
                        q   <= '0;
                        cnt <= WCNT'(NB - 1);
                    end
                end
                CALC: begin
                    if (!neg) begin
                        rad <= rad << 2;
                        rem <= ge ? (rem_sh - trial) : rem_sh;
                        q   <= {q[NB-2:0], ge};
                        cnt <= cnt - 1'b1;
                    end
                end
                FIN: begin
                    if (neg) begin
                        out      <= '0;
                        overflow <= 1'b1;
                    end else if (sat) begin
                        out      <= SAT_MAX[WO-1:0];
                        overflow <= 1'b1;
                    end else begin
                        out      <= r_ext[WO-1:0];
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
